// File: rtl/hazard.sv
// rtl/hazard.sv - RAW hazard scoreboard beside decode; optional HAZARD_RETIRE_BYPASS_EN
module hazard #(
  parameter int DEPTH = 4,
  localparam int OW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rs_valid_i,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic          issue_i,
  input  logic          issue_reg_write_i,
  input  logic [4:0]    issue_rd_i,
  input  logic          retire_i,
  output logic          stall_request_o,
  output logic [OW-1:0] occupancy_o,
  output logic [31:0]   stall_cycles_o,
  output logic          error_o
);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_we;
  logic [4:0]       ent_rd [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [OW-1:0]    count;

  logic match1;
  logic match2;
  logic full;
  logic push;
  logic pop;
  logic retire_hides;

  assign full  = (count == OW'(DEPTH));
  assign push  = issue_i && !stall_request_o;
  assign pop   = retire_i && (count != '0);
  assign occupancy_o = count;

`ifdef HAZARD_RETIRE_BYPASS_EN
  // The register file forwards the retiring write, so the oldest entry stops blocking this cycle.
  assign retire_hides = pop;
`else
  assign retire_hides = 1'b0;
`endif

  // Compare both decode sources against every pending writing entry.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_we[i] && !(retire_hides && (PW'(i) == rptr))) begin
        if (rs1_i != 5'd0 && ent_rd[i] == rs1_i) match1 = 1'b1;
        if (rs2_i != 5'd0 && ent_rd[i] == rs2_i) match2 = 1'b1;
      end
    end
  end

  // Stall on a dependency or a full scoreboard; forced low while reset is held.
  always_comb begin
    stall_request_o = 1'b0;
    if (!rst_i) stall_request_o = (rs_valid_i && (match1 || match2)) || full;
  end

  // Scoreboard FIFO: push at write pointer, pop at read pointer, count tracks the difference.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent_valid <= '0;
      ent_we    <= '0;
      for (int i = 0; i < DEPTH; i++) ent_rd[i] <= 5'd0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        ent_valid[rptr] <= 1'b0;
        rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      end
      // A push never lands on the popped slot: that would need count==DEPTH, which stalls.
      if (push) begin
        ent_valid[wptr] <= 1'b1;
        ent_we[wptr]    <= issue_reg_write_i && (issue_rd_i != 5'd0);
        ent_rd[wptr]    <= issue_rd_i;
        wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
    end else if (stall_request_o && stall_cycles_o != 32'hFFFF_FFFF) begin
      stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end

  // Sticky flag for issue-while-stalled and retire-while-empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      error_o <= 1'b0;
    end else if ((issue_i && stall_request_o) || (retire_i && count == '0)) begin
      error_o <= 1'b1;
    end
  end

endmodule
